// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage word accesses to a 16-bit SRAM as two halfword accesses
// (upper half first, at the even halfword address) with programmable wait states.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned SRAM_ADDR_W   = 18,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic [31:0]            write_data,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned WIDX_W   = SRAM_ADDR_W - 1;
    localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [WIDX_W-1:0] widx_r;
    logic [31:0]       wdata_r;
    logic              is_write_r;
    logic [15:0]       cap_hi_r;

    logic              req_s;
    logic [31:0]       offset_s;
    logic [WIDX_W-1:0] widx_s;
    logic              phase_end_s;

    // Request decode and word-index mapping; addresses below the base wrap silently.
    always_comb begin
        req_s       = mem_read | mem_write;
        offset_s    = addr - 32'(BASE_ADDR);
        widx_s      = WIDX_W'(offset_s >> 2);
        phase_end_s = (cnt_r == LAST_CNT);
    end

    // Ready drops combinationally in IDLE so the stage freezes the cycle a request appears.
    always_comb begin
        case (state_r)
            IDLE:    ready = ~req_s;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Access sequencer: SRAM pins are registered and set up on the edge entering each phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            widx_r      <= '0;
            wdata_r     <= 32'd0;
            is_write_r  <= 1'b0;
            cap_hi_r    <= 16'd0;
            read_data   <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        widx_r      <= widx_s;
                        wdata_r     <= write_data;
                        is_write_r  <= mem_write;
                        cnt_r       <= 4'd0;
                        state_r     <= HI;
                        sram_addr   <= {widx_s, 1'b0};
                        sram_dq_out <= write_data[31:16];
                        sram_dq_oe  <= mem_write;
                        sram_we_n   <= ~mem_write;
                    end
                end
                HI: begin
                    if (phase_end_s) begin
                        cnt_r       <= 4'd0;
                        state_r     <= LO;
                        sram_addr   <= {widx_r, 1'b1};
                        sram_dq_out <= wdata_r[15:0];
                        if (!is_write_r) begin
                            cap_hi_r <= sram_dq_in;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                LO: begin
                    if (phase_end_s) begin
                        cnt_r      <= 4'd0;
                        state_r    <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!is_write_r) begin
                            read_data <= {cap_hi_r, sram_dq_in};
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 4'd0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: one instance at ACCESS_CYCLES=2, one at 1,
// each with its own halfword SRAM model.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1;
    logic [17:0] saddr0, saddr1;
    logic [15:0] dqo0, dqo1, dqi0, dqi1;
    logic        oe0, oe1, wen0, wen1;

    logic [15:0] mem0 [0:63];
    logic [15:0] mem1 [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [15:0] pl_val;

    int checks_n = 0;
    int errors_n = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .write_data(wd0),
        .mem_read(rd0), .mem_write(wr0), .read_data(rdata0), .ready(ready0),
        .sram_addr(saddr0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
        .sram_dq_in(dqi0), .sram_we_n(wen0)
    );

    sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .write_data(wd1),
        .mem_read(rd1), .mem_write(wr1), .read_data(rdata1), .ready(ready1),
        .sram_addr(saddr1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
        .sram_dq_in(dqi1), .sram_we_n(wen1)
    );

    // SRAM models: asynchronous read, write committed on each clock edge while the strobe is low.
    assign dqi0 = mem0[saddr0[5:0]];
    assign dqi1 = mem1[saddr1[5:0]];

    always @(posedge clk) begin
        if (pl_en) mem0[pl_idx] <= pl_val;
        else if (!wen0 && oe0) mem0[saddr0[5:0]] <= dqo0;
    end

    always @(posedge clk) begin
        if (!wen1 && oe1) mem1[saddr1[5:0]] <= dqo1;
    end

    task automatic preload(input logic [5:0] idx, input logic [15:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One full access from cycle 0 through DONE, checked cycle by cycle against hand values.
    task automatic access_check(input string name, input bit sel, input int ac,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic rd, input logic wr,
                                input logic [17:0] hi_addr, input logic [31:0] word,
                                input logic [31:0] exp_rd);
        logic        o_ready, o_wen, o_oe, e_ready;
        logic [17:0] o_addr, e_addr;
        logic [15:0] o_dq, e_dq;
        logic [31:0] o_rd;
        if (sel) begin addr1 = a; wd1 = wd; rd1 = rd; wr1 = wr; end
        else begin addr0 = a; wd0 = wd; rd0 = rd; wr0 = wr; end
        for (int c = 0; c <= 2 * ac + 1; c++) begin
            @(negedge clk);
            if (sel) begin
                o_ready = ready1; o_wen = wen1; o_oe = oe1; o_addr = saddr1; o_dq = dqo1; o_rd = rdata1;
            end else begin
                o_ready = ready0; o_wen = wen0; o_oe = oe0; o_addr = saddr0; o_dq = dqo0; o_rd = rdata0;
            end
            e_ready = (c == 2 * ac + 1);
            checks_n++;
            if (o_ready !== e_ready) begin
                errors_n++;
                $display("FAIL %s ready cyc %0d: got %b expected %b", name, c, o_ready, e_ready);
            end
            if (c >= 1 && c <= 2 * ac) begin
                e_addr = (c <= ac) ? hi_addr : (hi_addr | 18'd1);
                e_dq   = (c <= ac) ? word[31:16] : word[15:0];
                checks_n++;
                if (o_addr !== e_addr) begin
                    errors_n++;
                    $display("FAIL %s sram_addr cyc %0d: got %h expected %h", name, c, o_addr, e_addr);
                end
                checks_n++;
                if (o_wen !== !wr || o_oe !== wr) begin
                    errors_n++;
                    $display("FAIL %s we_n/oe cyc %0d: got %b/%b expected %b/%b", name, c, o_wen, o_oe, !wr, wr);
                end
                if (wr) begin
                    checks_n++;
                    if (o_dq !== e_dq) begin
                        errors_n++;
                        $display("FAIL %s dq_out cyc %0d: got %h expected %h", name, c, o_dq, e_dq);
                    end
                end
            end
            if (c == 2 * ac + 1) begin
                checks_n++;
                if (o_wen !== 1'b1 || o_oe !== 1'b0) begin
                    errors_n++;
                    $display("FAIL %s done we_n/oe: got %b/%b expected 1/0", name, o_wen, o_oe);
                end
                checks_n++;
                if (o_rd !== exp_rd) begin
                    errors_n++;
                    $display("FAIL %s read_data: got %h expected %h", name, o_rd, exp_rd);
                end
            end
            @(posedge clk); #1;
        end
        if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
        else begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    task automatic check_mem(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks_n++;
            if (ready0 !== 1'b1 || rdata0 !== 32'd0 || wen0 !== 1'b1 || oe0 !== 1'b0) begin
                errors_n++;
                $display("FAIL reset_idle cyc %0d: got ready=%b rd=%h we_n=%b oe=%b expected 1/0/1/0",
                         i, ready0, rdata0, wen0, oe0);
            end
            @(posedge clk); #1;
        end
        checks_n++;
        if (saddr0 !== 18'd0 || dqo0 !== 16'd0) begin
            errors_n++;
            $display("FAIL reset_pins: got addr=%h dq=%h expected 0/0", saddr0, dqo0);
        end
    endtask

    task automatic test_store();
        access_check("store", 1'b0, 2, 32'd1028, 32'hC000_0000, 1'b0, 1'b1, 18'd2, 32'hC000_0000, 32'd0);
        check_mem("store_hw2", mem0[2], 16'hC000);
        check_mem("store_hw3", mem0[3], 16'h0000);
    endtask

    task automatic test_load();
        preload(6'd2, 16'hC000);
        preload(6'd3, 16'h0000);
        access_check("load", 1'b0, 2, 32'd1028, 32'd0, 1'b1, 1'b0, 18'd2, 32'hC000_0000, 32'hC000_0000);
    endtask

    task automatic test_back_to_back();
        access_check("b2b_str", 1'b0, 2, 32'd1024, 32'd8192, 1'b0, 1'b1, 18'd0, 32'h0000_2000, 32'hC000_0000);
        access_check("b2b_ldr", 1'b0, 2, 32'd1024, 32'd0, 1'b1, 1'b0, 18'd0, 32'h0000_2000, 32'h0000_2000);
        check_mem("b2b_hw0", mem0[0], 16'h0000);
        check_mem("b2b_hw1", mem0[1], 16'h2000);
    endtask

    task automatic test_reset_mid();
        preload(6'd5, 16'hBEEF);
        addr0 = 32'd1032; wd0 = 32'hAAAA_5555; wr0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; wr0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks_n++;
        if (ready0 !== 1'b1 || wen0 !== 1'b1 || oe0 !== 1'b0 || rdata0 !== 32'd0 || saddr0 !== 18'd0) begin
            errors_n++;
            $display("FAIL reset_mid: got ready=%b we_n=%b oe=%b rd=%h addr=%h expected 1/1/0/0/0",
                     ready0, wen0, oe0, rdata0, saddr0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_mem("reset_mid_hw5", mem0[5], 16'hBEEF);
    endtask

    task automatic test_both_asserted();
        access_check("both_ac2", 1'b0, 2, 32'd1040, 32'h1234_5678, 1'b1, 1'b1, 18'd8, 32'h1234_5678, 32'd0);
        check_mem("both_ac2_hw8", mem0[8], 16'h1234);
        check_mem("both_ac2_hw9", mem0[9], 16'h5678);
        access_check("both_ac1", 1'b1, 1, 32'd1040, 32'h1234_5678, 1'b1, 1'b1, 18'd8, 32'h1234_5678, 32'd0);
        check_mem("both_ac1_hw8", mem1[8], 16'h1234);
        check_mem("both_ac1_hw9", mem1[9], 16'h5678);
    endtask

    task automatic test_wrap();
        // (3 - 1024) >> 2 truncated to 17 bits is 0x1FF00, so the even halfword is 0x3FE00
        access_check("wrap", 1'b0, 2, 32'd3, 32'd0, 1'b1, 1'b0, 18'h3FE00, 32'h0000_2000, 32'h0000_2000);
    endtask

    initial begin
        rst = 1'b0;
        addr0 = 32'd0; wd0 = 32'd0; rd0 = 1'b0; wr0 = 1'b0;
        addr1 = 32'd0; wd1 = 32'd0; rd1 = 1'b0; wr1 = 1'b0;
        pl_en = 1'b0; pl_idx = 6'd0; pl_val = 16'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_both_asserted();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Sits between the MEM pipeline stage and an off-chip 16-bit asynchronous-style SRAM. It replaces the single-cycle byte-array data memory for data accesses. Each 32-bit word access from the MEM stage becomes two 16-bit SRAM accesses with programmable wait states. A ready signal stalls the pipeline until the access completes.

Parameters:
BASE_ADDR, 1024, byte address in the MEM-stage address space that maps to SRAM halfword 0.
SRAM_ADDR_W, 18, SRAM halfword address width.
ACCESS_CYCLES, 2, clock cycles each 16-bit SRAM access is held; legal values are 1 to 15.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  one clock; reset is synchronous and active-low.
addr  in  32  byte address from the MEM stage (ALU result).
write_data  in  32  store data from the MEM stage.
mem_read  in  1  load request; held by the stage until ready.
mem_write  in  1  store request; held by the stage until ready.
read_data  out  32  load result, registered.
ready  out  1  high means the pipeline may advance; low means freeze.
sram_addr  out  SRAM_ADDR_W  SRAM halfword address.
sram_dq_out  out  16  write data to the SRAM.
sram_dq_oe  out  1  pad output enable; high drives sram_dq_out.
sram_dq_in  in  16  read data from the SRAM pads.
sram_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- States are IDLE, HI, LO and DONE. A cycle counter cnt runs from 0 to ACCESS_CYCLES-1 within HI and LO.
- Reset (rst==0 at a rising edge):
  - state goes to IDLE, cnt to 0.
  - read_data, latched address and latched data all go to 0.
  - On the following cycle: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - A reset mid-access aborts the access. No further SRAM write strobe occurs and the partial read is discarded.
- req = mem_read | mem_write.
  - If both are asserted, the access is treated as a write. read_data is unchanged.
- IDLE:
  - ready = ~req, combinational, so it drops in the same cycle a request appears.
  - On an edge with req=1: latch word index widx = (addr - BASE_ADDR) >> 2 (low 2 addr bits ignored), latch write_data, latch is_write = mem_write. Go to HI with cnt=0.
- Address mapping:
  - Word address arithmetic is 32-bit two's complement, truncated to SRAM_ADDR_W-1 bits. Addresses below BASE_ADDR wrap silently.
  - HI accesses sram_addr = {widx, 1'b0}, carrying data bits [31:16].
  - LO accesses sram_addr = {widx, 1'b1}, carrying data bits [15:0].
  - Word data is big-endian: the upper half sits at the lower halfword address.
- HI and LO phases:
  - sram_addr is held stable for ACCESS_CYCLES cycles.
  - On writes: sram_dq_oe=1, sram_dq_out = the corresponding latched half, sram_we_n=0 for the whole phase.
  - On reads: sram_dq_oe=0, sram_we_n=1.
  - On the edge ending the last cycle of a phase (cnt==ACCESS_CYCLES-1), reads capture sram_dq_in into the corresponding half of a capture register. cnt then resets to 0 and the state goes HI->LO or LO->DONE.
  - ready=0 throughout.
- DONE (exactly one cycle):
  - ready=1, sram_we_n=1, sram_dq_oe=0.
  - For reads, read_data already equals the assembled word: updated on the edge entering DONE, valid during DONE, held until the next completed read.
  - Next state is IDLE unconditionally. The stage advances on this edge, so the same request is never replayed.
- Latency: a request first seen in cycle 0 gives ready=0 in cycles 0 through 2*ACCESS_CYCLES and ready=1 in cycle 2*ACCESS_CYCLES+1. The stall is 2*ACCESS_CYCLES+1 cycles.
- Back-to-back accesses: a new request in the cycle after DONE starts in IDLE with ready=0. There is no pipelining across accesses.
- Inputs addr, write_data, mem_read and mem_write are ignored outside IDLE. Only the latched values are used.
- Idle outputs: sram_we_n=1, sram_dq_oe=0, sram_addr and sram_dq_out hold their last values.

Test Plan:
1. Idle after reset, no requests → ready=1, read_data=0, sram_we_n=1, sram_dq_oe=0 for 10 cycles.
2. Store 0xC0000000 to addr 1028, ACCESS_CYCLES=2:
   - sram_addr=2 with dq 0xC000 and we_n low in cycles 1–2.
   - sram_addr=3 with dq 0x0000 and we_n low in cycles 3–4.
   - ready=1 only in cycle 5.
3. Load from 1028 with the SRAM model preloaded (halfword 2=0xC000, 3=0x0000) → read_data=0xC0000000 in cycle 5, ready low in cycles 0–4.
4. Back-to-back STR 8192 to 1024 then LDR from 1024 → two separate 5-cycle stalls; the LDR returns 0x00002000 and SRAM halfwords 0 and 1 equal 0x0000 and 0x2000.
5. Reset asserted in cycle 3 of a store to 1032 → next cycle: IDLE, we_n=1, oe=0, read_data=0; SRAM halfword 5 is not written.
6. mem_read and mem_write both high, write_data=0x12345678 at 1040 → a write is performed (halfwords 8 and 9 = 0x1234, 0x5678) and read_data is unchanged. Repeat with ACCESS_CYCLES=1: ready=1 in cycle 3.
